i2c_slave_regs: RTL

I2C responder (slave) that exposes a small byte-wide register file to an external I2C master on the redriver board. SCL and SDA are oversampled on SYSTEM_CLK. SDA is driven open-drain through an output-enable. The block decodes START/STOP, matches its 7-bit address, takes an offset byte, then accepts write bytes or returns read bytes with pointer auto-increment. A local read port and a write strobe let board logic consume the registers.

---
 rtl/i2c_slave_regs_if.sv | 26 ++
 rtl/i2c_slave_regs.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs_if.sv
// Pin and local-port bundle for the I2C register responder.
// The slave side is the responder; the master side is the board/pin environment.
`timescale 1ns/1ps
interface i2c_slave_regs_if #(
   parameter int IDX_W = 4
) ();
   logic             iSCL;
   logic             iSDA;
   logic             oSDAOE;
   logic [IDX_W-1:0] reg_rd_idx;
   logic [7:0]       reg_rd_data;
   logic             wr_stb;
   logic [IDX_W-1:0] wr_idx;
   logic [7:0]       wr_data;
   logic             busy;

   modport slave (
      input  iSCL, iSDA, reg_rd_idx,
      output oSDAOE, reg_rd_data, wr_stb, wr_idx, wr_data, busy
   );

   modport master (
      output iSCL, iSDA, reg_rd_idx,
      input  oSDAOE, reg_rd_data, wr_stb, wr_idx, wr_data, busy
   );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C responder exposing a byte register file; pin edge to action is 3 SYSTEM_CLK cycles.
// No backpressure: the block never stretches SCL, wr_stb is a fire-and-forget pulse.
`timescale 1ns/1ps
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         NUM_REGS   = 16,
   parameter int         IDX_W      = 4
) (
   input logic             SYSTEM_CLK,
   input logic             RESETn,
   i2c_slave_regs_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, OFFS, OFFS_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   logic [1:0]       scl_sync, sda_sync;
   logic             scl_q, sda_q;
   logic             scl_s, sda_s;
   logic             scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]       nxt_byte;

   state_t           state;
   logic [2:0]       bit_cnt;
   logic [6:0]       shreg;
   logic             rw;
   logic [IDX_W-1:0] ptr;
   logic             sda_oe;
   logic             busy_r;
   logic             wr_stb_r;
   logic [IDX_W-1:0] wr_idx_r;
   logic [7:0]       wr_data_r;
   logic [7:0]       rd_data_r;
   logic [7:0]       regs [NUM_REGS];

   // Synchronizers idle high so a reset release on an idle bus shows no edges.
   always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
      if (!RESETn) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], bus.iSCL};
         sda_sync <= {sda_sync[0], bus.iSDA};
         scl_q    <= scl_sync[1];
         sda_q    <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & scl_q & ~sda_s & sda_q;
   assign stop_det  = scl_s & scl_q & sda_s & ~sda_q;
   assign nxt_byte  = {shreg, sda_s};

   always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 7'd0;
         rw        <= 1'b0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         busy_r    <= 1'b0;
         wr_stb_r  <= 1'b0;
         wr_idx_r  <= '0;
         wr_data_r <= 8'd0;
         rd_data_r <= 8'd0;
         regs      <= '{default: 8'h00};
      end else begin
         wr_stb_r  <= 1'b0;
         rd_data_r <= regs[bus.reg_rd_idx];
         if (start_det) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 3'd0;
            state   <= ADDR;
         end else if (stop_det) begin
            sda_oe  <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shreg   <= nxt_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (nxt_byte[7:1] == SLAVE_ADDR) begin
                        rw     <= nxt_byte[0];
                        busy_r <= 1'b1;
                        state  <= ADDR_ACK;
                     end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                     end
                  end
               end
               // sda_oe doubles as the ACK phase flag: low on entry, high while acking.
               ADDR_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     bit_cnt <= 3'd0;
                     if (rw) begin
                        shreg  <= regs[ptr][6:0];
                        sda_oe <= ~regs[ptr][7];
                        state  <= RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= OFFS;
                     end
                  end
               end
               OFFS: if (scl_rise) begin
                  shreg   <= nxt_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr   <= nxt_byte[IDX_W-1:0];
                     state <= OFFS_ACK;
                  end
               end
               OFFS_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 3'd0;
                     state   <= WDATA;
                  end
               end
               WDATA: if (scl_rise) begin
                  shreg   <= nxt_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     regs[ptr] <= nxt_byte;
                     wr_stb_r  <= 1'b1;
                     wr_idx_r  <= ptr;
                     wr_data_r <= nxt_byte;
                     ptr       <= ptr + IDX_W'(1);
                     state     <= WDATA_ACK;
                  end
               end
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     ptr    <= ptr + IDX_W'(1);
                     state  <= RDATA_ACK;
                  end else begin
                     sda_oe  <= ~shreg[6];
                     shreg   <= {shreg[5:0], 1'b1};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               // A fall here can only follow a master ACK; NACK has already left.
               RDATA_ACK: begin
                  if (scl_rise && sda_s) begin
                     state <= IDLE;
                  end else if (scl_fall) begin
                     shreg   <= regs[ptr][6:0];
                     sda_oe  <= ~regs[ptr][7];
                     bit_cnt <= 3'd0;
                     state   <= RDATA;
                  end
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

   assign bus.oSDAOE      = sda_oe;
   assign bus.busy        = busy_r;
   assign bus.wr_stb      = wr_stb_r;
   assign bus.wr_idx      = wr_idx_r;
   assign bus.wr_data     = wr_data_r;
   assign bus.reg_rd_data = rd_data_r;

endmodule
